// File: rtl/exec_unit.sv
// exec_unit -- execute stage: register file, 8-op ALU and an optional
// shift-add multiplier, fed by a valid/ready instruction handshake.
//
// Build option:
//   EXEC_MUL_EN  when defined, op 111 is an unsigned multiply that runs for
//                DATA_W cycles; when undefined, op 111 is accepted as a NOP.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid / in_ready  instruction handshake (accept when both high)
//   op_code              operation select
//   src_addr1/src_addr2  operand A / operand B register addresses
//   dest_addr            destination register address
//   imm                  immediate used by LOADI
//   result               last written-back value
//   result_valid         one-cycle pulse after each write-back
//   flag_zero            last written-back value was zero
//   flag_carry           carry / borrow / shifted-out bit / product overflow
//   dbg_addr, dbg_data   combinational debug read of the register file

module exec_unit #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  localparam int ADDR_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] src_addr1,
  input  logic [ADDR_W-1:0] src_addr2,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              flag_zero,
  output logic              flag_carry,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_LOADI = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  logic [DATA_W-1:0] reg_file [REG_CNT];

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              accept;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_carry;

  assign opa      = reg_file[src_addr1];
  assign opb      = reg_file[src_addr2];
  assign dbg_data = reg_file[dbg_addr];
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU. The extra top bit of sum/diff is the carry/borrow.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, opa} + {1'b0, opb};
    diff      = {1'b0, opa} - {1'b0, opb};
    case (op_code)
      OP_ADD:   begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  end
      OP_SUB:   begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
      OP_AND:   alu_res = opa & opb;
      OP_OR:    alu_res = opa | opb;
      OP_XOR:   alu_res = opa ^ opb;
      OP_SHL:   begin alu_res = {opa[DATA_W-2:0], 1'b0}; alu_carry = opa[DATA_W-1]; end
      OP_LOADI: alu_res = imm;
      default:  alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state;
  state_t              next_state;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    iter;
  logic [ADDR_W-1:0]   mul_dest;
  logic                mul_last;
  logic [2*DATA_W-1:0] mul_sum;

  assign in_ready = (state == IDLE);
  assign mul_last = (state == MUL) && (iter == CNT_W'(DATA_W - 1));
  // Partial sum including this edge's iteration; on the last iteration this
  // is the full product, so write-back can use it directly.
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && op_code == OP_MUL) next_state = MUL;
      MUL:     if (mul_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift-add datapath: operands and destination are captured at accept so
  // the register file is free to change underneath the multiply.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      iter     <= '0;
      mul_dest <= '0;
    end else if (accept && op_code == OP_MUL) begin
      mcand    <= {{DATA_W{1'b0}}, opa};
      mplier   <= opb;
      acc      <= '0;
      iter     <= '0;
      mul_dest <= dest_addr;
    end else if (state == MUL) begin
      acc    <= mul_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      iter   <= iter + CNT_W'(1);
    end
  end
`else
  assign in_ready = 1'b1;
`endif

  // Write-back source select. Op 111 never writes back at accept; with the
  // multiplier built it writes back on its last iteration instead.
  always_comb begin
    wb_en    = accept && (op_code != OP_MUL);
    wb_addr  = dest_addr;
    wb_data  = alu_res;
    wb_carry = alu_carry;
`ifdef EXEC_MUL_EN
    if (mul_last) begin
      wb_en    = 1'b1;
      wb_addr  = mul_dest;
      wb_data  = mul_sum[DATA_W-1:0];
      wb_carry = |mul_sum[2*DATA_W-1:DATA_W];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) reg_file[i] <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
    end else begin
      result_valid <= wb_en;
      if (wb_en) begin
        reg_file[wb_addr] <= wb_data;
        result            <= wb_data;
        flag_zero         <= (wb_data == '0);
        flag_carry        <= wb_carry;
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit -- directed self-checking bench for exec_unit (default
// parameters: DATA_W=8, REG_CNT=4). Multiplier scenarios are compiled in
// when EXEC_MUL_EN is defined; otherwise the op 111 NOP behaviour is checked.

module tb_exec_unit;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op_code;
  logic [1:0] src_addr1;
  logic [1:0] src_addr2;
  logic [1:0] dest_addr;
  logic [7:0] imm;
  logic [7:0] result;
  logic       result_valid;
  logic       flag_zero;
  logic       flag_carry;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int compared;
  int mismatched;

  exec_unit #(.DATA_W(8), .REG_CNT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .src_addr1(src_addr1), .src_addr2(src_addr2),
    .dest_addr(dest_addr), .imm(imm), .result(result),
    .result_valid(result_valid), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [1:0] a1,
                           input logic [1:0] a2, input logic [1:0] d,
                           input logic [7:0] im);
    op_code   = op;
    src_addr1 = a1;
    src_addr2 = a2;
    dest_addr = d;
    imm       = im;
  endtask

  // Present one instruction for exactly one accept edge.
  task automatic issue(input logic [2:0] op, input logic [1:0] a1,
                       input logic [1:0] a2, input logic [1:0] d,
                       input logic [7:0] im);
    set_instr(op, a1, a2, d, im);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
    compared++; if (result !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_result: got %h want 00", result); end
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rv: got %b want 0", result_valid); end
    compared++; if ({flag_zero, flag_carry} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_flags: got %b want 00", {flag_zero, flag_carry}); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      rd = dbg_data;
      compared++; if (rd !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_reg%0d: got %h want 00", i, rd); end
    end
  endtask

  task automatic test_basic();
    issue(3'b110, 2'd0, 2'd0, 2'd1, 8'h05);
    compared++; if (result_valid !== 1'b1 || result !== 8'h05) begin mismatched++; $display("[TB] FAIL loadi_r1: got rv=%b res=%h want rv=1 res=05", result_valid, result); end
    issue(3'b110, 2'd0, 2'd0, 2'd2, 8'h03);
    compared++; if (result_valid !== 1'b1 || result !== 8'h03) begin mismatched++; $display("[TB] FAIL loadi_r2: got rv=%b res=%h want rv=1 res=03", result_valid, result); end
    issue(3'b000, 2'd1, 2'd2, 2'd3, 8'h00);
    compared++; if (result_valid !== 1'b1 || result !== 8'h08) begin mismatched++; $display("[TB] FAIL add_5_3: got rv=%b res=%h want rv=1 res=08", result_valid, result); end
    compared++; if ({flag_zero, flag_carry} !== 2'b00) begin mismatched++; $display("[TB] FAIL add_5_3_flags: got zc=%b want 00", {flag_zero, flag_carry}); end
    dbg_addr = 2'd3;
    #1;
    compared++; if (dbg_data !== 8'h08) begin mismatched++; $display("[TB] FAIL dbg_r3: got %h want 08", dbg_data); end
    tick();
    compared++; if (result_valid !== 1'b0 || result !== 8'h08) begin mismatched++; $display("[TB] FAIL rv_pulse_hold: got rv=%b res=%h want rv=0 res=08", result_valid, result); end
  endtask

  task automatic test_flags();
    issue(3'b110, 2'd0, 2'd0, 2'd1, 8'hFF);
    issue(3'b110, 2'd0, 2'd0, 2'd2, 8'h01);
    issue(3'b000, 2'd1, 2'd2, 2'd0, 8'h00);
    compared++; if ({result, flag_zero, flag_carry} !== {8'h00, 2'b11}) begin mismatched++; $display("[TB] FAIL add_wrap: got res=%h zc=%b want res=00 zc=11", result, {flag_zero, flag_carry}); end
    issue(3'b001, 2'd2, 2'd1, 2'd3, 8'h00);
    compared++; if ({result, flag_zero, flag_carry} !== {8'h02, 2'b01}) begin mismatched++; $display("[TB] FAIL sub_borrow: got res=%h zc=%b want res=02 zc=01", result, {flag_zero, flag_carry}); end
    issue(3'b101, 2'd1, 2'd0, 2'd1, 8'h00);
    compared++; if ({result, flag_zero, flag_carry} !== {8'hFE, 2'b01}) begin mismatched++; $display("[TB] FAIL shl_ff: got res=%h zc=%b want res=FE zc=01", result, {flag_zero, flag_carry}); end
    issue(3'b100, 2'd1, 2'd1, 2'd1, 8'h00);
    compared++; if ({result, flag_zero, flag_carry} !== {8'h00, 2'b10}) begin mismatched++; $display("[TB] FAIL xor_self: got res=%h zc=%b want res=00 zc=10", result, {flag_zero, flag_carry}); end
    // r2=01, r3=02 at this point
    issue(3'b011, 2'd2, 2'd3, 2'd0, 8'h00);
    compared++; if ({result, flag_zero, flag_carry} !== {8'h03, 2'b00}) begin mismatched++; $display("[TB] FAIL or_1_2: got res=%h zc=%b want res=03 zc=00", result, {flag_zero, flag_carry}); end
    issue(3'b010, 2'd0, 2'd3, 2'd0, 8'h00);
    compared++; if (result !== 8'h02) begin mismatched++; $display("[TB] FAIL and_3_2: got %h want 02", result); end
    issue(3'b000, 2'd2, 2'd2, 2'd2, 8'h00);
    compared++; if (result !== 8'h02) begin mismatched++; $display("[TB] FAIL add_dest_is_src: got %h want 02", result); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_res [6];
    int pulses;
    exp_res = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h40};
    pulses = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: set_instr(3'b110, 2'd0, 2'd0, 2'd0, 8'h10);
        1: set_instr(3'b110, 2'd0, 2'd0, 2'd1, 8'h20);
        2: set_instr(3'b000, 2'd0, 2'd1, 2'd2, 8'h00);
        3: set_instr(3'b001, 2'd1, 2'd0, 2'd3, 8'h00);
        4: set_instr(3'b100, 2'd2, 2'd3, 2'd0, 8'h00);
        default: set_instr(3'b101, 2'd1, 2'd0, 2'd1, 8'h00);
      endcase
      tick();
      if (result_valid === 1'b1) pulses++;
      compared++; if (result !== exp_res[k]) begin mismatched++; $display("[TB] FAIL b2b_res%0d: got %h want %h", k, result, exp_res[k]); end
    end
    in_valid = 1'b0;
    compared++; if (pulses !== 6) begin mismatched++; $display("[TB] FAIL b2b_pulses: got %0d want 6", pulses); end
    tick();
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_rv: got %b want 0", result_valid); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    issue(3'b110, 2'd0, 2'd0, 2'd1, 8'h10);
    issue(3'b110, 2'd0, 2'd0, 2'd2, 8'h11);
    issue(3'b111, 2'd1, 2'd2, 2'd3, 8'h00);
    // Held instruction waits out the multiply.
    set_instr(3'b110, 2'd0, 2'd0, 2'd0, 8'hAA);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      compared++; if (in_ready !== 1'b0 || result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mul_busy%0d: got ready=%b rv=%b want 0 0", k, in_ready, result_valid); end
      tick();
    end
    compared++; if (result_valid !== 1'b1 || result !== 8'h10) begin mismatched++; $display("[TB] FAIL mul_result: got rv=%b res=%h want rv=1 res=10", result_valid, result); end
    compared++; if ({flag_zero, flag_carry, in_ready} !== 3'b011) begin mismatched++; $display("[TB] FAIL mul_flags_ready: got zcr=%b want 011", {flag_zero, flag_carry, in_ready}); end
    dbg_addr = 2'd0;
    #1;
    compared++; if (dbg_data !== 8'h20) begin mismatched++; $display("[TB] FAIL mul_held_not_taken: got r0=%h want 20", dbg_data); end
    tick();
    in_valid = 1'b0;
    compared++; if (result_valid !== 1'b1 || result !== 8'hAA) begin mismatched++; $display("[TB] FAIL mul_held_taken: got rv=%b res=%h want rv=1 res=AA", result_valid, result); end
  endtask

  task automatic test_mul_abort();
    int seen;
    issue(3'b111, 2'd1, 2'd2, 2'd0, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++; if (in_ready !== 1'b1 || result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_state: got ready=%b rv=%b want 1 0", in_ready, result_valid); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      compared++; if (dbg_data !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_reg%0d: got %h want 00", i, dbg_data); end
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (result_valid !== 1'b0) seen++;
    end
    compared++; if (seen !== 0) begin mismatched++; $display("[TB] FAIL abort_no_rv: got %0d pulses want 0", seen); end
  endtask
`else
  task automatic test_nop();
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL nop_ready_before: got %b want 1", in_ready); end
    issue(3'b111, 2'd1, 2'd2, 2'd0, 8'h5A);
    compared++; if (result_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL nop_rv_ready: got rv=%b ready=%b want 0 1", result_valid, in_ready); end
    compared++; if ({result, flag_zero, flag_carry} !== {8'h40, 2'b00}) begin mismatched++; $display("[TB] FAIL nop_result_hold: got res=%h zc=%b want res=40 zc=00", result, {flag_zero, flag_carry}); end
    dbg_addr = 2'd0;
    #1;
    compared++; if (dbg_data !== 8'h20) begin mismatched++; $display("[TB] FAIL nop_r0_unchanged: got %h want 20", dbg_data); end
    tick();
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL nop_rv_later: got %b want 0", result_valid); end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    in_valid   = 1'b0;
    dbg_addr   = 2'd0;
    set_instr(3'b000, 2'd0, 2'd0, 2'd0, 8'h00);
    #1;
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_nop();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
